// File: rtl/multi_pulse_width_detector.sv
// N-channel edge detector and pulse-width classifier: flags edges, sorts each completed
// high pulse into short / in-window / long and keeps a saturating in-window count per channel.
module multi_pulse_width_detector #(
    parameter int N     = 4,
    parameter int MIN_W = 1,
    parameter int MAX_W = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       a,
    input  logic               clr,
    output logic [N-1:0]       rise,
    output logic [N-1:0]       fall,
    output logic [N-1:0]       pulse_ok,
    output logic [N-1:0]       pulse_short,
    output logic [N-1:0]       pulse_long,
    output logic [N-1:0]       overrun,
    output logic [N*CNT_W-1:0] ok_count
);

    localparam int CW = $clog2(MAX_W + 2);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_W);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_W);
    localparam logic [CW-1:0] SAT_C = CW'(MAX_W + 1);

    logic [N-1:0]     a_r_q, a_r_d;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];
    logic [CNT_W-1:0] okc_q [N];
    logic [CNT_W-1:0] okc_d [N];

    // cnt holds the width of the high run ending at a_r, saturating so long pulses stay "long"
    always_comb begin
        a_r_d       = rst ? '0 : a;
        rise        = '0;
        fall        = '0;
        pulse_ok    = '0;
        pulse_short = '0;
        pulse_long  = '0;
        overrun     = '0;
        ok_count    = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            okc_d[i] = okc_q[i];
            ok_count[i*CNT_W +: CNT_W] = okc_q[i];
            if (!rst) begin
                rise[i]        = a[i] & ~a_r_q[i];
                fall[i]        = ~a[i] & a_r_q[i];
                pulse_ok[i]    = fall[i] & (cnt_q[i] >= MIN_C) & (cnt_q[i] <= MAX_C);
                pulse_short[i] = fall[i] & (cnt_q[i] < MIN_C);
                pulse_long[i]  = fall[i] & (cnt_q[i] > MAX_C);
                overrun[i]     = a[i] & a_r_q[i] & (cnt_q[i] == MAX_C);
                if (a[i]) begin
                    cnt_d[i] = (cnt_q[i] == SAT_C) ? SAT_C : cnt_q[i] + 1'b1;
                end
            end
            // clear takes priority over a coincident in-window pulse
            if (rst || clr) begin
                okc_d[i] = '0;
            end else if (pulse_ok[i] && (okc_q[i] != '1)) begin
                okc_d[i] = okc_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        a_r_q <= a_r_d;
        for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
            okc_q[i] <= okc_d[i];
        end
    end

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Directed plus random bench for multi_pulse_width_detector (N=2, window [2,4], 2-bit counters),
// checked every cycle against an unsaturated run-length reference model.
module tb_multi_pulse_width_detector;

    localparam int N     = 2;
    localparam int MIN_W = 2;
    localparam int MAX_W = 4;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] ok;
        logic [1:0] sh;
        logic [1:0] lg;
        logic [1:0] ov;
        logic [3:0] cnt;
        logic       chk_cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] a   = 2'b00;
    logic [1:0] rise, fall, pulse_ok, pulse_short, pulse_long, overrun;
    logic [3:0] ok_count;

    int   vectors     = 0;
    int   miscompares = 0;
    int   run_len [2] = '{0, 0};
    bit   prev_a  [2] = '{1'b0, 1'b0};
    int   okc     [2] = '{0, 0};
    bit   cnt_known   = 1'b0;
    exp_t exp_q [$];

    int         widths  [4] = '{1, 2, 4, 5};
    logic [2:0] sweep_cls [4] = '{3'b010, 3'b100, 3'b100, 3'b001};
    int         sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [6:0] b2b_a    = 7'b0111011;
    logic [6:0] b2b_rise = 7'b0001001;
    logic [6:0] b2b_fall = 7'b1000100;

    multi_pulse_width_detector #(
        .N(N), .MIN_W(MIN_W), .MAX_W(MAX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .clr(clr),
        .rise(rise), .fall(fall), .pulse_ok(pulse_ok), .pulse_short(pulse_short),
        .pulse_long(pulse_long), .overrun(overrun), .ok_count(ok_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at negedge, predict, queue, then compare what the DUT shows.
    task automatic applyStimulus(input logic [1:0] av, input logic c, input logic r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        a = av;
        clr = c;
        rst = r;
        #1;
        e = '0;
        e.chk_cnt = cnt_known;
        for (int i = 0; i < 2; i++) begin
            e.cnt[i*2 +: 2] = 2'(okc[i]);
            if (!r) begin
                e.rise[i] = av[i] && !prev_a[i];
                e.fall[i] = !av[i] && prev_a[i];
                e.ok[i]   = e.fall[i] && run_len[i] >= MIN_W && run_len[i] <= MAX_W;
                e.sh[i]   = e.fall[i] && run_len[i] < MIN_W;
                e.lg[i]   = e.fall[i] && run_len[i] > MAX_W;
                e.ov[i]   = av[i] && prev_a[i] && run_len[i] == MAX_W;
            end
        end
        exp_q.push_back(e);
        got = exp_q.pop_front();
        checkOutput("rise", {6'd0, rise}, {6'd0, got.rise});
        checkOutput("fall", {6'd0, fall}, {6'd0, got.fall});
        checkOutput("pulse_ok", {6'd0, pulse_ok}, {6'd0, got.ok});
        checkOutput("pulse_short", {6'd0, pulse_short}, {6'd0, got.sh});
        checkOutput("pulse_long", {6'd0, pulse_long}, {6'd0, got.lg});
        checkOutput("overrun", {6'd0, overrun}, {6'd0, got.ov});
        if (got.chk_cnt) checkOutput("ok_count", {4'd0, ok_count}, {4'd0, got.cnt});
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                prev_a[i]  = 1'b0;
                run_len[i] = 0;
                okc[i]     = 0;
            end else begin
                if (c) okc[i] = 0;
                else if (e.ok[i] && okc[i] < 3) okc[i] = okc[i] + 1;
                prev_a[i]  = av[i];
                run_len[i] = av[i] ? run_len[i] + 1 : 0;
            end
        end
        if (r) cnt_known = 1'b1;
    endtask

    initial begin
        // reset with both inputs high
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, 1'b0, 1'b1);
            checkOutput("rst_flags", {2'b00, rise, fall, overrun}, 8'h00);
        end
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("post_rst_rise", {6'd0, rise}, 8'h03);
        checkOutput("post_rst_count", {4'd0, ok_count}, 8'h00);
        applyStimulus(2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // width sweep on channel 0
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < widths[k]; j++) begin
                applyStimulus(2'b01, 1'b0, 1'b0);
                checkOutput("sweep_overrun", {7'd0, overrun[0]},
                            {7'd0, (widths[k] == 5 && j == 4)});
            end
            applyStimulus(2'b00, 1'b0, 1'b0);
            checkOutput("sweep_class", {5'd0, pulse_ok[0], pulse_short[0], pulse_long[0]},
                        {5'd0, sweep_cls[k]});
            applyStimulus(2'b00, 1'b0, 1'b0);
        end
        checkOutput("sweep_count", {6'd0, ok_count[1:0]}, 8'd2);

        // saturation on channel 1
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) applyStimulus(2'b10, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b0, 1'b0);
            checkOutput("sat_count", {6'd0, ok_count[3:2]}, 8'(sat_exp[k]));
        end
        for (int j = 0; j < 3; j++) applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("clr_ok", {7'd0, pulse_ok[1]}, 8'd1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("clr_count", {4'd0, ok_count}, 8'd0);

        // back-to-back pulses on channel 0
        for (int k = 0; k < 7; k++) begin
            applyStimulus({1'b0, b2b_a[k]}, 1'b0, 1'b0);
            checkOutput("b2b_flags",
                        {2'b00, rise[0], fall[0], pulse_ok[0], pulse_short[0], pulse_long[0], overrun[0]},
                        {2'b00, b2b_rise[k], b2b_fall[k], b2b_fall[k], 3'b000});
        end
        applyStimulus(2'b00, 1'b0, 1'b0);

        // reset in the middle of a channel 1 pulse
        for (int j = 0; j < 3; j++) applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b1);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("midrst_rise", {6'd0, rise}, 8'h02);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("midrst_class", {5'd0, pulse_ok[1], pulse_short[1], pulse_long[1]}, 8'h04);

        // random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            applyStimulus(2'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
